mul_acc_unit: RTL and testbench

MUL_ACC_UNIT -- requirements
Module: mul_acc_unit

---
 rtl/mul_acc_pkg.sv | 6 +
 rtl/mul_acc_datapath.sv | 42 ++++
 rtl/mul_acc_unit.sv | 69 ++++++
 tb/tb_mul_acc_unit.sv | 102 ++++++++++
 4 files changed

// File: rtl/mul_acc_pkg.sv
// mul_acc_pkg: shared defaults and FSM state encoding for the shift-add multiply-accumulate unit.
package mul_acc_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 5;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;
endpackage

// File: rtl/mul_acc_datapath.sv
// mul_acc_datapath: operand shift registers, accumulator, adder and iteration counter.
module mul_acc_datapath
    import mul_acc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             acc_sel,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [WIDTH-1:0] opc,
    output logic [WIDTH-1:0] sum,
    output logic             last
);
    logic [WIDTH-1:0] mcand_q, mcand_d, mplr_q, mplr_d, acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        sum     = acc_q + (mplr_q[0] ? mcand_q : '0);
        last    = cnt_q == CNT_W'(WIDTH - 1);
        mcand_d = load ? opa : step ? mcand_q << 1 : mcand_q;
        mplr_d  = load ? opb : step ? mplr_q >> 1 : mplr_q;
        acc_d   = load ? (acc_sel ? opc : '0) : step ? sum : acc_q;
        cnt_d   = load ? '0 : step ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/mul_acc_unit.sv
// mul_acc_unit: fixed-latency MUL/MLA unit, IDLE/RUN/FIN control around a shift-add datapath.
module mul_acc_unit
    import mul_acc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             ACC,
    input  logic             ABORT,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    input  logic [WIDTH-1:0] OPC,
    output logic [WIDTH-1:0] RESULT,
    output logic             N,
    output logic             Z,
    output logic             BUSY,
    output logic             DONE
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, sum;
    logic             n_q, n_d, z_q, z_d, busy_q, busy_d, done_q, done_d;
    logic             load, step, last, finish;

    mul_acc_datapath #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dp (
        .clk(CLK), .rst(RESET), .load(load), .step(step), .acc_sel(ACC),
        .opa(OPA), .opb(OPB), .opc(OPC), .sum(sum), .last(last)
    );

    // The final iteration's sum is captured directly on the edge that enters FIN.
    always_comb begin
        load     = state_q == IDLE && START;
        step     = state_q == RUN;
        finish   = step && !ABORT && last;
        state_d  = state_q == IDLE ? (START ? RUN : IDLE) :
                   state_q == RUN  ? (ABORT ? IDLE : last ? FIN : RUN) : IDLE;
        result_d = finish ? sum : result_q;
        n_d      = finish ? sum[WIDTH-1] : n_q;
        z_d      = finish ? sum == '0 : z_q;
        busy_d   = state_d != IDLE;
        done_d   = state_d == FIN;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            result_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            n_q      <= n_d;
            z_q      <= z_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign RESULT = result_q;
    assign N      = n_q;
    assign Z      = z_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
endmodule

// File: tb/tb_mul_acc_unit.sv
// tb_mul_acc_unit: directed and random MUL/MLA operations checked against an arithmetic reference.
module tb_mul_acc_unit;
    logic        CLK = 1'b0, RESET = 1'b1, START = 1'b0, ACC = 1'b0, ABORT = 1'b0;
    logic [31:0] OPA = '0, OPB = '0, OPC = '0, RESULT;
    logic        N, Z, BUSY, DONE;
    int          checks = 0, errors = 0;
    logic [31:0] prev_r = '0;
    logic        prev_n = 1'b0, prev_z = 1'b1;

    mul_acc_unit dut (
        .CLK(CLK), .RESET(RESET), .START(START), .ACC(ACC), .ABORT(ABORT),
        .OPA(OPA), .OPB(OPB), .OPC(OPC), .RESULT(RESULT), .N(N), .Z(Z),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle i is the interval after the (i-1)th edge following the START-sampling edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic acc, input bit noise, input bit abt);
        logic [31:0] e;
        e = a * b + (acc ? c : 32'd0);
        OPA = a; OPB = b; OPC = c; ACC = acc; START = 1'b1; ABORT = abt;
        for (int i = 1; i <= 34; i++) begin
            @(negedge CLK);
            check("done", {63'd0, DONE}, {63'd0, i == 33});
            check("busy", {63'd0, BUSY}, {63'd0, i <= 33});
            if (i == 33) begin
                check("result", {32'd0, RESULT}, {32'd0, e});
                check("n", {63'd0, N}, {63'd0, e[31]});
                check("z", {63'd0, Z}, {63'd0, e == 32'd0});
            end else if (i < 33) begin
                check("hold", {32'd0, RESULT}, {32'd0, prev_r});
            end
            ABORT = 1'b0;
            START = noise && i >= 5 && i <= 20;
            if (START) begin
                OPA = $urandom; OPB = $urandom; OPC = $urandom; ACC = ~ACC;
            end
        end
        prev_r = e; prev_n = e[31]; prev_z = e == 32'd0;
    endtask

    task automatic cut_op(input bit use_rst);
        int ev;
        ev = use_rst ? 15 : 10;
        OPA = $urandom; OPB = $urandom; OPC = $urandom; ACC = 1'b1; START = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            @(negedge CLK);
            check("cut_done", {63'd0, DONE}, 64'd0);
            check("cut_busy", {63'd0, BUSY}, {63'd0, i <= ev});
            check("cut_res", {32'd0, RESULT}, (use_rst && i > ev) ? 64'd0 : {32'd0, prev_r});
            if (i > ev) begin
                check("cut_n", {63'd0, N}, use_rst ? 64'd0 : {63'd0, prev_n});
                check("cut_z", {63'd0, Z}, use_rst ? 64'd1 : {63'd0, prev_z});
            end
            START = 1'b0;
            ABORT = !use_rst && i == ev;
            RESET = use_rst && i == ev;
        end
        if (use_rst) begin
            prev_r = '0; prev_n = 1'b0; prev_z = 1'b1;
        end
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check("rst_res", {32'd0, RESULT}, 64'd0);
        check("rst_n", {63'd0, N}, 64'd0);
        check("rst_z", {63'd0, Z}, 64'd1);
        check("rst_busy", {63'd0, BUSY}, 64'd0);
        check("rst_done", {63'd0, DONE}, 64'd0);
        RESET = 1'b0;
        ABORT = 1'b1;
        @(negedge CLK);
        check("idle_abort", {63'd0, BUSY}, 64'd0);
        ABORT = 1'b0;
        run_op(32'd3, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b0, 1'b0);
        run_op(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++)
            run_op($urandom, $urandom, $urandom, 1'($urandom), 1'b0, 1'b0);
        run_op($urandom, $urandom, $urandom, 1'b1, 1'b1, 1'b0);
        run_op($urandom, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
        run_op($urandom, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
        cut_op(1'b0);
        run_op($urandom, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
        cut_op(1'b1);
        run_op($urandom, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
